// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with pending-write scoreboard
// Optional WB_FWD_EN: exposes writeback forwarding instead of stalling on the in-flight write.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            sb_set,
    input  logic [4:0]      sb_rd,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    input  logic [4:0]      q_rd,
    output logic            hazard,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
`ifdef WB_FWD_EN
    ,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  wait_cnt;
    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        inflight_stall;

    // B wins when A is idle or once B has waited STARVE_MAX cycles in a row
    always_comb begin
        b_ready = b_valid && (!a_valid || (wait_cnt == STARVE_LIM));
        a_ready = a_valid && !b_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!b_valid || b_ready) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != STARVE_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (b_ready) begin
            rf_we    <= (b_rd != 5'd0);
            rf_waddr <= b_rd;
            rf_wdata <= b_data;
        end else if (a_ready) begin
            rf_we    <= (a_rd != 5'd0);
            rf_waddr <= a_rd;
            rf_wdata <= a_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Set is OR-ed in after the clear so a same-cycle set/clear leaves the bit pending
    always_comb begin
        set_mask = (sb_set && (sb_rd != 5'd0)) ? (32'd1 << sb_rd) : 32'd0;
        clr_mask = b_ready ? (32'd1 << b_rd) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 32'd0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    function automatic logic pend_hit(input logic [4:0] r);
        return (r != 5'd0) && pending[r];
    endfunction

    function automatic logic inflight_hit(input logic [4:0] r);
        return (r != 5'd0) && rf_we && (rf_waddr == r);
    endfunction

`ifdef WB_FWD_EN
    assign inflight_stall = 1'b0;
    assign fwd1_hit       = inflight_hit(q_rs1);
    assign fwd2_hit       = inflight_hit(q_rs2);
    assign fwd_data       = rf_wdata;
`else
    assign inflight_stall = inflight_hit(q_rs1) | inflight_hit(q_rs2);
`endif

    assign hazard = pend_hit(q_rs1) | pend_hit(q_rs2) | pend_hit(q_rd) | inflight_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table-driven bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, sb_set;
    logic [4:0]  a_rd, b_rd, sb_rd, q_rs1, q_rs2, q_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, hazard, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_FWD_EN
        , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
`endif
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        bv;  logic [4:0] brd; logic [31:0] bd;
        logic        sbs; logic [4:0] sbrd;
        logic [4:0]  q1;  logic [4:0] q2;  logic [4:0] qd;
        logic        ear; logic ebr; logic ehz; logic einf; logic ewe;
        logic [4:0]  ewa; logic [31:0] ewd;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input int av, input int ard, input int ad,
                     input int bv, input int brd, input int bd,
                     input int sbs, input int sbrd,
                     input int q1, input int q2, input int qd,
                     input int ar, input int br, input int hz, input int inf,
                     input int we, input int wa, input int wd);
        vec_t r;
        r.av = 1'(av);   r.ard = 5'(ard); r.ad = 32'(ad);
        r.bv = 1'(bv);   r.brd = 5'(brd); r.bd = 32'(bd);
        r.sbs = 1'(sbs); r.sbrd = 5'(sbrd);
        r.q1 = 5'(q1);   r.q2 = 5'(q2);   r.qd = 5'(qd);
        r.ear = 1'(ar);  r.ebr = 1'(br);  r.ehz = 1'(hz); r.einf = 1'(inf);
        r.ewe = 1'(we);  r.ewa = 5'(wa);  r.ewd = 32'(wd);
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        sb_set = 0; sb_rd = 0; q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    endtask

    task automatic chk_hz(input string nm, input logic hz, input logic inf);
`ifdef WB_FWD_EN
        chk({nm, ".hazard"}, 32'(hazard), 32'(hz & ~inf));
        chk({nm, ".fwd1_hit"}, 32'(fwd1_hit), 32'(inf));
        if (inf) chk({nm, ".fwd_data"}, fwd_data, rf_wdata);
`else
        chk({nm, ".hazard"}, 32'(hazard), 32'(hz));
        if (inf) chk({nm, ".inflight"}, 32'(rf_we), 32'd1);
`endif
    endtask

    initial begin
        //  av ard ad       bv brd bd      sbs sbrd q1 q2 qd  ar br hz inf we wa wd
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
        v(1, 5, 'h1234,   0, 0, 0,       0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 0);
        v(0, 0, 0,        0, 0, 0,       0, 0,  5, 0, 0,  0, 0, 1, 1,  1, 5, 'h1234);
        v(0, 0, 0,        0, 0, 0,       0, 0,  5, 0, 0,  0, 0, 0, 0,  0, 5, 'h1234);
        v(0, 0, 0,        0, 0, 0,       1, 7,  7, 0, 0,  0, 0, 0, 0,  0, 5, 'h1234);
        v(0, 0, 0,        0, 0, 0,       0, 0,  7, 0, 0,  0, 0, 1, 0,  0, 5, 'h1234);
        v(0, 0, 0,        1, 7, 'hbeef,  0, 0,  7, 0, 0,  0, 1, 1, 0,  0, 5, 'h1234);
        v(0, 0, 0,        0, 0, 0,       0, 0,  7, 0, 0,  0, 0, 1, 1,  1, 7, 'hbeef);
        v(0, 0, 0,        0, 0, 0,       0, 0,  7, 0, 0,  0, 0, 0, 0,  0, 7, 'hbeef);
        v(0, 0, 0,        1, 9, 'h99,    1, 9,  0, 0, 0,  0, 1, 0, 0,  0, 7, 'hbeef);
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 9,  0, 0, 1, 0,  1, 9, 'h99);
        v(0, 0, 0,        1, 9, 'h55,    1, 0,  0, 0, 0,  0, 1, 0, 0,  0, 9, 'h99);
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 9,  0, 0, 0, 0,  1, 9, 'h55);
        v(1, 0, 'haaaa,   0, 0, 0,       0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 9, 'h55);
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 'haaaa);
        // A and B contend: four A grants, then B, repeating
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 0, 'haaaa);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  0, 1, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 2, 'h22);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 2, 'h22,    0, 0,  0, 0, 0,  0, 1, 0, 0,  1, 1, 'h11);
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 2, 'h22);
        v(0, 0, 0,        1, 3, 'h33,    0, 0,  0, 0, 0,  0, 1, 0, 0,  0, 2, 'h22);
        v(1, 1, 'h11,     1, 4, 'h44,    0, 0,  0, 0, 0,  1, 0, 0, 0,  1, 3, 'h33);
        v(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 0,  0, 0, 0, 0,  1, 1, 'h11);
        v(1, 1, 'h11,     1, 4, 'h44,    0, 0,  0, 0, 0,  1, 0, 0, 0,  0, 1, 'h11);

        reset = 1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 0;

        foreach (tbl[i]) begin
            string nm;
            @(negedge clk);
            a_valid = tbl[i].av;  a_rd = tbl[i].ard;  a_data = tbl[i].ad;
            b_valid = tbl[i].bv;  b_rd = tbl[i].brd;  b_data = tbl[i].bd;
            sb_set = tbl[i].sbs;  sb_rd = tbl[i].sbrd;
            q_rs1 = tbl[i].q1;    q_rs2 = tbl[i].q2;  q_rd = tbl[i].qd;
            #2;
            nm = $sformatf("vec%0d", i);
            chk({nm, ".a_ready"}, 32'(a_ready), 32'(tbl[i].ear));
            chk({nm, ".b_ready"}, 32'(b_ready), 32'(tbl[i].ebr));
            chk_hz(nm, tbl[i].ehz, tbl[i].einf);
            chk({nm, ".rf_we"}, 32'(rf_we), 32'(tbl[i].ewe));
            chk({nm, ".rf_waddr"}, 32'(rf_waddr), 32'(tbl[i].ewa));
            chk({nm, ".rf_wdata"}, rf_wdata, tbl[i].ewd);
        end

        // Reset mid-stall with a write in flight: everything must clear
        @(negedge clk);
        drive_idle();
        sb_set = 1; sb_rd = 3; a_valid = 1; a_rd = 6; a_data = 32'h66;
        @(negedge clk);
        drive_idle();
        q_rs1 = 3; reset = 1;
        #2;
        chk("rst.pre_hazard", 32'(hazard), 32'd1);
        chk("rst.pre_rf_we", 32'(rf_we), 32'd1);
        chk("rst.pre_rf_waddr", 32'(rf_waddr), 32'd6);
        @(negedge clk);
        reset = 0;
        #2;
        chk("rst.hazard", 32'(hazard), 32'd0);
        chk("rst.rf_we", 32'(rf_we), 32'd0);
        chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst.rf_wdata", rf_wdata, 32'd0);

        // Starvation counter must restart after the reset
        @(negedge clk);
        drive_idle();
        for (int c = 0; c < 5; c++) begin
            a_valid = 1; a_rd = 1; a_data = 32'h1;
            b_valid = 1; b_rd = 2; b_data = 32'h2;
            #2;
            chk($sformatf("starve%0d.b_ready", c), 32'(b_ready), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d.a_ready", c), 32'(a_ready), (c == 4) ? 32'd0 : 32'd1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
